// File: rtl/updown_cnt_arb_if.sv
// ---------------------------------------------------------------------------
// updown_cnt_arb_if
//   Bundles the command handshakes of both requesters plus the counter status
//   outputs of updown_cnt_arb.
//   master : requester/control side (drives valid/dir/len/clr, sees the rest)
//   slave  : counter block side
// Signals
//   reqN_valid/dir/len  command from requester N (dir 1 = up)
//   reqN_ready          command accepted this cycle
//   clr                 synchronous clear of q
//   q                   counter value
//   busy                command in progress
//   owner               current or last granted requester
//   done, done_id       one-cycle completion pulse and its requester id
//   sat_hit             previous step was clipped (saturating build only)
// ---------------------------------------------------------------------------
interface updown_cnt_arb_if #(
    parameter int WIDTH = 3,
    parameter int LEN_W = 4
);
    logic             req0_valid;
    logic             req0_dir;
    logic [LEN_W-1:0] req0_len;
    logic             req0_ready;
    logic             req1_valid;
    logic             req1_dir;
    logic [LEN_W-1:0] req1_len;
    logic             req1_ready;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             owner;
    logic             done;
    logic             done_id;
    logic             sat_hit;

    modport master (
        output req0_valid, req0_dir, req0_len,
        output req1_valid, req1_dir, req1_len,
        output clr,
        input  req0_ready, req1_ready,
        input  q, busy, owner, done, done_id, sat_hit
    );

    modport slave (
        input  req0_valid, req0_dir, req0_len,
        input  req1_valid, req1_dir, req1_len,
        input  clr,
        output req0_ready, req1_ready,
        output q, busy, owner, done, done_id, sat_hit
    );
endinterface

// File: rtl/updown_cnt_arb.sv
// ---------------------------------------------------------------------------
// updown_cnt_arb
//   Shared up/down step counter behind a two-requester round-robin command
//   arbiter. A granted command {dir, len} steps q once per clock for len
//   clocks, then raises a one-cycle done pulse tagged with the requester id.
// Ports
//   clk    clock, all logic on posedge
//   rst_n  synchronous reset, active-low
//   bus    updown_cnt_arb_if.slave: both command handshakes, clr, q, busy,
//          owner, done, done_id, sat_hit
// Configuration
//   CNT_SAT_EN  defined  : q saturates at 0 / max, sat_hit flags clipped steps
//               undefined: q wraps modulo 2^WIDTH, sat_hit stays 0
// ---------------------------------------------------------------------------
module updown_cnt_arb #(
    parameter int WIDTH = 3,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    updown_cnt_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             owner_q, owner_d;
    logic             rr_q, rr_d;        // 0: req0 wins a tie, 1: req1 wins
    logic             sat_hit_q, sat_hit_d;

    logic             gnt_any;
    logic             gnt_id;
    logic [LEN_W-1:0] len_sel;
    logic             rdy0, rdy1;
    logic [WIDTH:0]   step_res;          // {clipped, next q}

    // One counter step; returns {clipped, next value}.
    function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] cur,
                                               input logic             up);
        logic [WIDTH-1:0] nxt;
        logic             clip;
        clip = 1'b0;
        if (up) nxt = cur + 1'b1;
        else    nxt = cur - 1'b1;
`ifdef CNT_SAT_EN
        if (up && (cur == {WIDTH{1'b1}})) begin
            nxt  = cur;
            clip = 1'b1;
        end else if (!up && (cur == '0)) begin
            nxt  = cur;
            clip = 1'b1;
        end
`endif
        return {clip, nxt};
    endfunction

    // Round-robin: on a tie the pointer decides, a lone valid always wins.
    always_comb begin
        gnt_any = bus.req0_valid | bus.req1_valid;
        gnt_id  = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
        len_sel = gnt_id ? bus.req1_len : bus.req0_len;
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        sat_hit_d = 1'b0;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        step_res  = step_fn(q_q, dir_q);

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    rdy0    = ~gnt_id;
                    rdy1    = gnt_id;
                    dir_d   = gnt_id ? bus.req1_dir : bus.req0_dir;
                    rem_d   = len_sel;
                    owner_d = gnt_id;
                    rr_d    = ~gnt_id;
                    state_d = (len_sel != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                q_d       = step_res[WIDTH-1:0];
                sat_hit_d = step_res[WIDTH];
                rem_d     = rem_q - 1'b1;
                if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // clr wins over a step; the step slot is still used up by rem above.
        if (bus.clr) begin
            q_d       = '0;
            sat_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            q_q       <= '0;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            sat_hit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            sat_hit_q <= sat_hit_d;
        end
    end

    // Command payload: only read while RUN, which reset leaves.
    always_ff @(posedge clk) begin
        dir_q <= dir_d;
        rem_q <= rem_d;
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.q          = q_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.owner      = owner_q;
    assign bus.done       = (state_q == DONE);
    assign bus.done_id    = owner_q;
    assign bus.sat_hit    = sat_hit_q;

endmodule
